// File: rtl/mlaccel_memarb.sv
// Two-requester (host / compute) arbiter in front of a single-port memory.
// Each grant runs a fixed three-cycle sequence IDLE -> ACCESS -> DONE.
module mlaccel_memarb #(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              h_read,
  input  logic [1:0]        h_write,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [15:0]       h_wdata,
  input  logic              c_read,
  input  logic [1:0]        c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [15:0]       c_wdata,
  input  logic              c_hold,
  output logic              h_done,
  output logic              c_done,
  output logic [63:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wen,
  output logic [15:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_c_q, last_c_d;
  logic              gnt_c_q, gnt_c_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        wen_q, wen_d;
  logic [15:0]       wdata_q, wdata_d;

  logic h_pend;
  logic c_pend;
  logic pick_c;

  assign h_pend = h_read | (|h_write);
  assign c_pend = (c_read | (|c_write)) & ~c_hold;

  // On a tie the side that did not win last time gets the grant.
  assign pick_c = (h_pend & c_pend) ? ~last_c_q : c_pend;

  always_comb begin
    state_d  = state_q;
    last_c_d = last_c_q;
    gnt_c_d  = gnt_c_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (h_pend | c_pend) begin
          state_d  = ST_ACCESS;
          gnt_c_d  = pick_c;
          last_c_d = pick_c;
          addr_d   = pick_c ? c_addr  : h_addr;
          wen_d    = pick_c ? c_write : h_write;
          wdata_d  = pick_c ? c_wdata : h_wdata;
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      last_c_q <= 1'b1;
      gnt_c_q  <= 1'b0;
      addr_q   <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_c_q <= last_c_d;
      gnt_c_q  <= gnt_c_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
    end
  end

  // A nonzero lane mask makes the access a write; read is implied otherwise.
  assign mem_addr  = (state_q == ST_ACCESS) ? addr_q  : '0;
  assign mem_wen   = (state_q == ST_ACCESS) ? wen_q   : 2'b00;
  assign mem_wdata = (state_q == ST_ACCESS) ? wdata_q : 16'h0000;

  assign h_done = (state_q == ST_DONE) & ~gnt_c_q;
  assign c_done = (state_q == ST_DONE) &  gnt_c_q;
  assign rdata  = (state_q == ST_DONE) ? mem_rdata : 64'h0;
  assign busy   = (state_q != ST_IDLE);

endmodule
